// File: rtl/lvt_pkg.sv
// Shared definitions for the LVT memory and its read-side streamer:
// default geometry and the streamer FSM state encoding.
package lvt_pkg;

  localparam int LVT_ADDR_W = 7;
  localparam int LVT_DATA_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/lvt_rd_streamer_if.sv
// Command and output-stream bundle of the LVT read streamer.
// The master modport is the streamer; the slave modport is the commander/consumer.
interface lvt_rd_streamer_if
  import lvt_pkg::*;
#(
  parameter int ADDR_W = LVT_ADDR_W,
  parameter int DATA_W = LVT_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/rd_skid_fifo.sv
// Synchronous FIFO with a registered head word and an occupancy count,
// used as the output buffer of the read streamer.
module rd_skid_fifo
  import lvt_pkg::*;
#(
  parameter  int WIDTH = LVT_DATA_W + 1,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] ram_q [DEPTH];
  logic [WIDTH-1:0] ram_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    ram_d    = ram_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push) begin
      ram_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head tracks ram[rd_ptr]: take the next stored word, or bypass an
    // incoming word when the FIFO is (or is about to become) empty.
    if (pop && count_q > CNT_W'(1)) begin
      head_d = ram_q[rd_ptr_d];
    end else if (push && (count_q == '0 || (pop && count_q == CNT_W'(1)))) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: the storage array is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    ram_q <= ram_d;
  end

  assign head_data = head_q;
  assign count     = count_q;

endmodule

// File: rtl/lvt_rd_streamer.sv
// Read-side burst engine for the LVT RAM: turns (addr, len) commands into
// credit-limited back-to-back reads and a valid/ready stream with a last flag.
module lvt_rd_streamer
  import lvt_pkg::*;
#(
  parameter int ADDR_W     = LVT_ADDR_W,
  parameter int DATA_W     = LVT_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  lvt_rd_streamer_if.master   io,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] lst_q, lst_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight;
  logic [DATA_W:0]   head;
  logic              credit_ok;
  logic              issue;
  logic              pop;

  // Reads in flight plus buffered words may never exceed the FIFO depth,
  // so returning data always has a slot regardless of back-pressure.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_q[i]);
    credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  end

  assign issue = (state_q == ISSUE) && credit_ok;
  assign pop   = io.out_valid && io.out_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        // A zero-length command is consumed here without leaving IDLE.
        if (io.cmd_valid && io.cmd_len != '0) begin
          addr_d   = io.cmd_addr;
          remain_d = io.cmd_len;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - (ADDR_W + 1)'(1);
          if (remain_q == (ADDR_W + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[DATA_W]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue-flag pipe mirrors the memory latency; its last tap marks valid read data.
  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = issue;
    lst_d[0] = issue && (remain_q == (ADDR_W + 1)'(1));
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      vld_q    <= '0;
      lst_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      vld_q    <= vld_d;
      lst_q    <= lst_d;
    end
  end

  rd_skid_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_q[RD_LAT-1]),
    .push_data ({lst_q[RD_LAT-1], mem_rd_data}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  assign mem_rd_en    = issue;
  assign mem_rd_addr  = addr_q;
  assign busy         = (state_q != IDLE);
  assign io.cmd_ready = (state_q == IDLE);
  assign io.out_valid = (fifo_count != '0);
  assign io.out_data  = head[DATA_W-1:0];
  assign io.out_last  = head[DATA_W];

endmodule

// File: tb/tb_lvt_rd_streamer.sv
// Self-checking bench for lvt_rd_streamer: behavioural memory, expected-beat
// scoreboard filled at command accept, and an independent output monitor.
module tb_lvt_rd_streamer;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 5;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_SZ     = 1 << ADDR_W;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvt_rd_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) io ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;

  lvt_rd_streamer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (io),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .busy        (busy)
  );

  // Memory read port: data appears RD_LAT cycles after a sampled strobe,
  // garbage otherwise so stray captures are visible.
  logic [DATA_W-1:0] mem     [MEM_SZ];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd_en ? mem[mem_rd_addr] : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the driver appends, the monitor consumes by index.
  beat_t             exp_q[$];
  logic [ADDR_W-1:0] iss_addr_q[$];
  int  rd_idx      = 0;
  int  hs_cnt      = 0;
  int  iss_cnt     = 0;
  int  last_cnt    = 0;
  int  outstanding = 0;
  time last_hs_time = 0;

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_idx      = exp_q.size();
        outstanding = 0;
      end else begin
        if (mem_rd_en) begin
          iss_addr_q.push_back(mem_rd_addr);
          iss_cnt++;
          outstanding++;
          check("outstanding_le_depth", outstanding <= FIFO_DEPTH, 1);
        end
        if (io.out_valid && io.out_ready) begin
          check("beat_expected", rd_idx < exp_q.size(), 1);
          if (rd_idx < exp_q.size()) begin
            b = exp_q[rd_idx];
            check("beat_data", io.out_data, b.data);
            check("beat_last", io.out_last, b.last);
          end
          rd_idx++;
          hs_cnt++;
          outstanding--;
          if (io.out_last) begin
            last_cnt++;
            last_hs_time = $time;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input int addr, input int len);
    beat_t b;
    io.cmd_valid = 1'b1;
    io.cmd_addr  = ADDR_W'(addr);
    io.cmd_len   = (ADDR_W + 1)'(len);
    for (int k = 0; k < 3000 && !io.cmd_ready; k++) step();
    check("cmd_ready_before_accept", io.cmd_ready, 1);
    step();
    io.cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      b.last = (i == len - 1);
      b.data = mem[(addr + i) % MEM_SZ];
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input bit rand_ready);
    for (int k = 0; k < 3000 && busy; k++) begin
      if (rand_ready) io.out_ready = ($urandom % 4) != 0;
      step();
    end
    check("burst_completes", busy, 0);
    check("cmd_ready_when_idle", io.cmd_ready, 1);
    check("busy_falls_cycle_after_last", 32'($time - last_hs_time), 6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, h0, l0, i0, blocked, addr, len, r;
    io.cmd_valid = 1'b0;
    io.cmd_addr  = '0;
    io.cmd_len   = '0;
    io.out_ready = 1'b0;
    for (int i = 0; i < MEM_SZ; i++) mem[i] = DATA_W'($urandom);
    mem[10] = 5'd5; mem[11] = 5'd6; mem[12] = 5'd7; mem[127] = 5'd9; mem[0] = 5'd3;

    #1;
    check("rst_cmd_ready", io.cmd_ready, 1);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_data", io.out_data, 0);
    check("rst_out_last", io.out_last, 0);
    check("rst_busy", busy, 0);
    repeat (3) step();
    rst = 1'b0;

    // Basic burst with first-word latency
    io.out_ready = 1'b1;
    h0 = hs_cnt; l0 = last_cnt;
    do_cmd(10, 3);
    check("basic_rd_en", mem_rd_en, 1);
    check("basic_rd_addr", mem_rd_addr, 10);
    check("basic_busy", busy, 1);
    check("basic_cmd_ready_low", io.cmd_ready, 0);
    step();
    check("basic_valid_not_early", io.out_valid, 0);
    step();
    check("basic_first_valid", io.out_valid, 1);
    check("basic_first_data", io.out_data, 5);
    wait_idle(0);
    check("basic_beats", hs_cnt - h0, 3);
    check("basic_one_last", last_cnt - l0, 1);

    // Address wrap
    i0 = iss_addr_q.size();
    do_cmd(127, 2);
    wait_idle(0);
    check("wrap_issue_count", iss_addr_q.size() - i0, 2);
    check("wrap_addr0", iss_addr_q[i0], 127);
    check("wrap_addr1", iss_addr_q[i0+1], 0);

    // Back-pressure on a short burst
    io.out_ready = 1'b0;
    n0 = iss_cnt; h0 = hs_cnt;
    do_cmd(10, 3);
    repeat (10) step();
    check("bp_issues", iss_cnt - n0, 3);
    check("bp_no_beats", hs_cnt - h0, 0);
    check("bp_valid_held", io.out_valid, 1);
    check("bp_busy", busy, 1);
    io.out_ready = 1'b1;
    wait_idle(0);
    check("bp_beats", hs_cnt - h0, 3);

    // Credit exhaustion and resume after a single pop
    io.out_ready = 1'b0;
    n0 = iss_cnt;
    do_cmd(20, 20);
    repeat (12) step();
    check("full_issues", iss_cnt - n0, FIFO_DEPTH);
    check("full_rd_en_low", mem_rd_en, 0);
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    check("full_resume_after_pop", mem_rd_en, 1);
    step();
    check("full_stall_again", mem_rd_en, 0);
    io.out_ready = 1'b1;
    wait_idle(0);

    // Zero-length command is a no-op, next command goes straight in
    n0 = iss_cnt; h0 = hs_cnt;
    do_cmd(5, 0);
    check("zl_busy", busy, 0);
    check("zl_cmd_ready", io.cmd_ready, 1);
    check("zl_rd_en", mem_rd_en, 0);
    repeat (3) step();
    check("zl_no_issue", iss_cnt - n0, 0);
    check("zl_no_beats", hs_cnt - h0, 0);
    check("zl_no_valid", io.out_valid, 0);
    do_cmd(12, 1);
    check("zl_next_rd_en", mem_rd_en, 1);
    check("zl_next_rd_addr", mem_rd_addr, 12);
    wait_idle(0);

    // Asynchronous reset in the middle of a burst
    h0 = hs_cnt;
    do_cmd(10, 3);
    for (int k = 0; k < 50 && hs_cnt == h0; k++) step();
    check("mr_first_beat", hs_cnt - h0, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_rd_en", mem_rd_en, 0);
    check("mr_rd_addr", mem_rd_addr, 0);
    check("mr_out_valid", io.out_valid, 0);
    check("mr_out_data", io.out_data, 0);
    check("mr_out_last", io.out_last, 0);
    check("mr_busy", busy, 0);
    check("mr_cmd_ready", io.cmd_ready, 1);
    step();
    step();
    rst = 1'b0;
    h0 = hs_cnt;
    do_cmd(11, 1);
    wait_idle(0);
    check("mr_single_beat", hs_cnt - h0, 1);

    // Command held valid during a burst is blocked until idle
    do_cmd(10, 3);
    io.cmd_valid = 1'b1;
    io.cmd_addr  = ADDR_W'(127);
    io.cmd_len   = (ADDR_W + 1)'(2);
    blocked = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      if (io.cmd_ready) blocked++;
      step();
    end
    check("blk_ready_low_while_busy", blocked, 0);
    check("blk_busy_fell", busy, 0);
    check("blk_ready_rises", io.cmd_ready, 1);
    check("blk_busy_after_last", 32'($time - last_hs_time), 6);
    do_cmd(127, 2);
    check("blk_second_rd_en", mem_rd_en, 1);
    check("blk_second_rd_addr", mem_rd_addr, 127);
    wait_idle(0);

    // Randomized commands with random back-pressure
    for (int t = 0; t < 25; t++) begin
      addr = int'($urandom % MEM_SZ);
      r    = int'($urandom % 8);
      len  = (r == 0) ? 0 : (r == 1) ? MEM_SZ : 1 + int'($urandom % 12);
      io.out_ready = $urandom % 2;
      do_cmd(addr, len);
      if (len > 0) wait_idle(1);
    end

    io.out_ready = 1'b1;
    repeat (5) step();
    check("all_beats_delivered", rd_idx, exp_q.size());
    check("nothing_outstanding", outstanding, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
